// File: rtl/uart_tx_if.sv
// Byte handshake into the UART transmitter FIFO.
// Push happens on a clock edge with VALID && READY.
interface uart_tx_if;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;

  modport master (
    output DATA,
    output VALID,
    input  READY
  );

  modport slave (
    input  DATA,
    input  VALID,
    output READY
  );
endinterface

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter, LSB first, with a byte FIFO.
// Define UART_TX_PARITY_EN to add an even parity bit (11-bit frames).
module uart_tx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     CLK,
  input  logic     RESET,
  uart_tx_if.slave bus,
  output logic     TXD,
  output logic     BUSY
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t state, state_n;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          ready_q;
  logic          push;
  logic          pop;
  logic          empty;
  logic [7:0]    head;

  logic [BW-1:0] baud;
  logic          baud_end;
  logic [7:0]    shift;
  logic [2:0]    idx;
  logic          adv;
  logic          txd_n;
`ifdef UART_TX_PARITY_EN
  logic          par;
`endif

  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  assign baud_end = (baud == BAUD_LAST);

  // Accept only when not full, even if a pop lands on the same edge.
  assign push = bus.VALID && ready_q && (count != FULL) && !RESET;

  assign bus.READY = ready_q;
  assign BUSY      = (state != ST_IDLE) || !empty;

  always_comb begin
    count_n = count;
    unique case (1'b1)
      push && !pop: count_n = count + 1'b1;
      pop && !push: count_n = count - 1'b1;
      default:      count_n = count;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_n;
      ready_q <= (count_n < FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    txd_n   = TXD;
    pop     = 1'b0;
    adv     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        txd_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          txd_n   = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          txd_n   = shift[0];
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_n   = par;
            state_n = ST_PARITY;
`else
            txd_n   = 1'b1;
            state_n = ST_STOP;
`endif
          end else begin
            adv   = 1'b1;
            txd_n = shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_end) begin
          txd_n   = 1'b1;
          state_n = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (baud_end) begin
          txd_n = 1'b1;
          // Chain straight into the next start bit when data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            txd_n   = 1'b0;
            state_n = ST_START;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: begin
        txd_n   = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      TXD   <= 1'b1;
      baud  <= '0;
      shift <= '0;
      idx   <= '0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      TXD <= txd_n;
      if (state == ST_IDLE || baud_end) begin
        baud <= '0;
      end else begin
        baud <= baud + 1'b1;
      end
      if (pop) begin
        shift <= head;
        idx   <= '0;
`ifdef UART_TX_PARITY_EN
        par   <= ^head;
`endif
      end else if (adv) begin
        shift <= {1'b0, shift[7:1]};
        idx   <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Randomised scoreboard bench for uart_tx: a line monitor rebuilds
// each frame's waveform from the queued byte and compares it sample by sample.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * CPB;

  logic CLK;
  logic RESET;
  logic TXD;
  logic BUSY;

  uart_tx_if bus();

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus),
    .TXD(TXD),
    .BUSY(BUSY)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nframes = 0;

  logic [7:0] exp_q[$];
  logic [7:0] tx_bytes[$];
  int         acc_q[$];
  int         starts[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  function automatic logic [FL-1:0] model_frame(input logic [7:0] b);
    logic [FL-1:0] w;
    logic lvl;
    w = '0;
    for (int j = 0; j < FB; j++) begin
      if (j == 0) lvl = 1'b0;
      else if (j <= 8) lvl = b[j-1];
      else if (FB == 11 && j == 9) lvl = ^b;
      else lvl = 1'b1;
      for (int c = 0; c < CPB; c++) w[j*CPB + c] = lvl;
    end
    return w;
  endfunction

  always begin : mon
    int st;
    bit ab;
    logic [7:0] b;
    logic [FL-1:0] lv;
    logic [FL-1:0] ev;
    @(negedge CLK);
    if (!RESET && TXD === 1'b0) begin
      st = cyc;
      ab = 1'b0;
      lv = '0;
      lv[0] = TXD;
      for (int k = 1; k < FL; k++) begin
        @(negedge CLK);
        if (RESET) begin
          ab = 1'b1;
          break;
        end
        lv[k] = TXD;
      end
      if (!ab) begin
        starts.push_back(st);
        nframes++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame%0d: got unexpected frame %b expected none", nframes, lv);
        end else begin
          b = exp_q.pop_front();
          ev = model_frame(b);
          if (lv !== ev) begin
            errors++;
            $display("FAIL frame%0d byte %02h: got %b expected %b", nframes, b, lv, ev);
          end
        end
      end
    end
  end

  task automatic at_cyc(input int t);
    @(negedge CLK);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic push_burst(output int first_stall);
    int i;
    int stall;
    logic rdy;
    i = 0;
    stall = 0;
    first_stall = -1;
    acc_q.delete();
    @(posedge CLK);
    #1;
    bus.VALID = 1'b1;
    bus.DATA  = tx_bytes[0];
    while (i < tx_bytes.size()) begin
      @(negedge CLK);
      rdy = bus.READY;
      if (!rdy && first_stall < 0) first_stall = i;
      @(posedge CLK);
      #1;
      if (rdy) begin
        exp_q.push_back(tx_bytes[i]);
        acc_q.push_back(cyc);
        i++;
        if (i < tx_bytes.size()) bus.DATA = tx_bytes[i];
      end else begin
        stall++;
        if (stall > 2000) begin
          chk("push_timeout", i, tx_bytes.size());
          break;
        end
      end
    end
    bus.VALID = 1'b0;
    if (first_stall < 0) first_stall = tx_bytes.size();
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (nframes < n && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    if (nframes < n) chk("frame_timeout", nframes, n);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge CLK);
    while ((BUSY || exp_q.size() != 0) && t < 5000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 5000) chk("idle_timeout", BUSY, 0);
  endtask

  task automatic single(input logic [7:0] b);
    int n0;
    int fs;
    int nacc;
    n0 = nframes;
    tx_bytes.delete();
    tx_bytes.push_back(b);
    push_burst(fs);
    nacc = acc_q[0];
    at_cyc(nacc + FL);
    chk("busy_end_of_frame", BUSY, 1);
    at_cyc(nacc + FL + 1);
    chk("busy_after_frame", BUSY, 0);
    wait_frames(n0 + 1);
    if (starts.size() > n0) chk("start_latency", starts[n0], nacc + 1);
  endtask

  initial begin : main
    int fs;
    int n0;
    int s;
    RESET = 1'b1;
    bus.VALID = 1'b0;
    bus.DATA  = 8'h00;

    repeat (3) begin
      @(negedge CLK);
      chk("reset_lines", {TXD, BUSY, bus.READY}, 3'b100);
    end
    bus.VALID = 1'b1;
    bus.DATA  = 8'hA5;
    @(posedge CLK);
    #1;
    bus.VALID = 1'b0;
    RESET = 1'b0;
    @(posedge CLK);
    repeat (100) begin
      @(negedge CLK);
      chk("idle_lines", {TXD, BUSY, bus.READY}, 3'b101);
    end

    single(8'h55);
    wait_idle();

    n0 = nframes;
    tx_bytes.delete();
    for (int i = 1; i <= 6; i++) tx_bytes.push_back(8'(i));
    push_burst(fs);
    chk("burst_accepts", fs, DEPTH + 1);
    chk("burst_ready_rise", acc_q[5], acc_q[0] + FL + 2);
    wait_frames(n0 + 6);
    if (starts.size() >= n0 + 6) begin
      chk("burst_first_start", starts[n0], acc_q[0] + 1);
      for (int i = 1; i < 6; i++)
        chk("burst_gap", starts[n0+i] - starts[n0+i-1], FL);
    end
    wait_idle();

    single(8'h07);
    wait_idle();
    single(8'h03);
    wait_idle();

    n0 = nframes;
    tx_bytes.delete();
    tx_bytes.push_back(8'($urandom));
    tx_bytes.push_back(8'($urandom));
    push_burst(fs);
    @(negedge CLK);
    chk("pushpop_count", dut.count, 1);
    chk("pushpop_adjacent", acc_q[1], acc_q[0] + 1);
    wait_frames(n0 + 2);
    if (starts.size() >= n0 + 2) chk("pushpop_start", starts[n0], acc_q[0] + 1);
    wait_idle();

    tx_bytes.delete();
    for (int i = 0; i < 3; i++) tx_bytes.push_back(8'($urandom));
    push_burst(fs);
    s = acc_q[0] + 1;
    at_cyc(s + 4 * CPB + 1);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_txd", TXD, 1);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_q.delete();
    n0 = nframes;
    repeat (200) @(negedge CLK);
    chk("abort_busy", BUSY, 0);
    chk("abort_no_frames", nframes, n0);
    chk("abort_ready", bus.READY, 1);

    for (int it = 0; it < 15; it++) begin
      tx_bytes.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++)
        tx_bytes.push_back(8'($urandom));
      push_burst(fs);
      repeat ($urandom_range(0, 60)) @(posedge CLK);
    end
    wait_idle();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_busy", BUSY, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
